// File: rtl/bcd_7seg_pkg.sv
// rtl/bcd_7seg_pkg.sv - 7448-style segment codes and decode helper for the scan driver
package bcd_7seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    // {a,b,c,d,e,f,g}; codes 10..14 are the 7448 glyphs, 15 is dark
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h1F, 7'h70,
        7'h7F, 7'h73, 7'h0D, 7'h19, 7'h23, 7'h4B, 7'h0F, 7'h00
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/bcd_lzb_mask.sv
// rtl/bcd_lzb_mask.sv - multi-digit leading-zero blanking mask and ripple-blank output
module bcd_lzb_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic                    i_rbi_n,
    output logic [NUM_DIGITS-1:0]   o_blank,
    output logic                    o_rbo_n
);

    logic w_upper_zero;

    // Walk from the most significant digit down; digit 0 always stays visible.
    always_comb begin
        o_blank      = '0;
        w_upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_upper_zero = w_upper_zero & (i_digits[4*k +: 4] == 4'd0);
            o_blank[k]   = ~i_rbi_n & w_upper_zero;
        end
    end

    assign o_rbo_n = i_rbi_n | (|i_digits);

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// rtl/bcd_7seg_scan_driver.sv - multiplexed BCD 7-segment scan driver; BCD_SCAN_DIM_EN adds PWM dimming
module bcd_7seg_scan_driver
    import bcd_7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lt_n,
    input  logic                    bi_n,
    input  logic                    rbi_n,
`ifdef BCD_SCAN_DIM_EN
    input  logic [3:0]              dim_level,
`endif
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    rbo_n
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_FIRST = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_bank;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_rbo_n;
    logic [3:0]            w_digit;
    logic [6:0]            w_seg_next;

    bcd_lzb_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb (
        .i_digits (r_bank),
        .i_rbi_n  (rbi_n),
        .o_blank  (w_blank),
        .o_rbo_n  (w_rbo_n)
    );

    assign w_digit = r_bank[4*r_idx +: 4];

`ifdef BCD_SCAN_DIM_EN
    logic [3:0] r_pwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pwm <= 4'd0;
        else     r_pwm <= r_pwm + 4'd1;
    end
`endif

    // BI beats LT beats the ripple-blank mask; dimming gates whatever survives.
    always_comb begin
        w_seg_next = seg_decode(w_digit);
        if (!bi_n)               w_seg_next = SEG_BLANK;
        else if (!lt_n)          w_seg_next = SEG_ALL;
        else if (w_blank[r_idx]) w_seg_next = SEG_BLANK;
`ifdef BCD_SCAN_DIM_EN
        if (r_pwm >= dim_level)  w_seg_next = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_bank <= '0;
            r_seg  <= SEG_BLANK;
            r_an   <= '0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (load) r_bank <= bcd_in;
            r_seg <= w_seg_next;
            r_an  <= AN_FIRST << r_idx;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign rbo_n = w_rbo_n | rst;

endmodule
